// File: rtl/lcd_pkg.sv
// Shared constants, enums and helpers for the LCD frame scheduler.
package lcd_pkg;

    localparam logic [1:0] OPER_INSTR = 2'b00;
    localparam logic [1:0] OPER_DATA  = 2'b01;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_QUEST = 8'h3F;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_B     = 8'h42;

    localparam logic [4:0] INIT_LAST = 5'd3;
    localparam logic [4:0] LINE_LAST = 5'd16;

    typedef enum logic [1:0] {FR_INIT, FR_REFRESH, FR_MESSAGE} frame_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_LOW, ST_WAIT_HIGH} state_e;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] bcd_char(input logic [3:0] d);
        return (d <= 4'd9) ? (CH_ZERO + {4'h0, d}) : CH_QUEST;
    endfunction

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// Command port between the frame scheduler (master) and the LCD driver (slave).
interface lcd_frame_scheduler_if;
    logic [7:0] lcd_data;
    logic [1:0] lcd_oper;
    logic       lcd_enb;
    logic       lcd_rdy;

    modport master (output lcd_data, lcd_oper, lcd_enb, input lcd_rdy);
    modport slave  (input lcd_data, lcd_oper, lcd_enb, output lcd_rdy);
endinterface

// File: rtl/lcd_msg_rom.sv
// Fixed 16-character line-2 messages, one character per (msg_id, idx).
module lcd_msg_rom (
    input  logic [1:0] msg_id_i,
    input  logic [3:0] idx_i,
    output logic [7:0] char_o
);
    logic [127:0] line_s;

    // Message select; character 0 sits in the top byte, so its base bit is {~idx,3'b111}.
    always_comb begin
        case (msg_id_i)
            2'd0:    line_s = "SET TIME        ";
            2'd1:    line_s = "A WINS ON TIME  ";
            2'd2:    line_s = "B WINS ON TIME  ";
            default: line_s = "PAUSED          ";
        endcase
        char_o = line_s[{~idx_i, 3'b111} -: 8];
    end
endmodule

// File: rtl/lcd_frame_scheduler.sv
// Shares the LCD command port between init, line-1 refresh and line-2 message frames,
// issuing one byte per RDY handshake with a per-byte timeout.
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [7:0]  L1_ADDR     = 8'h80,
    parameter logic [7:0]  L2_ADDR     = 8'hC0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           count_time_i,
    input  logic                  refresh_tick_i,
    input  logic                  msg_req_i,
    input  logic [1:0]            msg_id_i,
    output logic                  msg_ack_o,
    lcd_frame_scheduler_if.master lcd,
    output logic                  busy_o,
    output logic                  err_o
);
    state_e      state_q;
    frame_e      frame_q;
    logic [4:0]  idx_q;
    logic [15:0] tmo_q;
    logic [31:0] snap_q;
    logic [1:0]  msg_id_q;
    logic        init_pend_q, refresh_pend_q, msg_pend_q;
    logic        msg_ack_q, err_q, enb_q;
    logic [7:0]  data_q;
    logic [1:0]  oper_q;

    logic [3:0]  pos_s;
    logic [7:0]  rom_char_s, line1_s, byte_d;
    logic [1:0]  oper_d;
    logic        last_s, tmo_hit_s, abort_s, done_s;

    assign pos_s = idx_q[3:0] - 4'd1;

    lcd_msg_rom u_msg_rom (
        .msg_id_i (msg_id_q),
        .idx_i    (pos_s),
        .char_o   (rom_char_s)
    );

    // Line-1 character at position pos_s: "A mm:ss  B mm:ss" from the snapshot.
    always_comb begin
        case (pos_s)
            4'd0:    line1_s = CH_A;
            4'd2:    line1_s = bcd_char(snap_q[31:28]);
            4'd3:    line1_s = bcd_char(snap_q[27:24]);
            4'd4:    line1_s = CH_COLON;
            4'd5:    line1_s = bcd_char(snap_q[23:20]);
            4'd6:    line1_s = bcd_char(snap_q[19:16]);
            4'd9:    line1_s = CH_B;
            4'd11:   line1_s = bcd_char(snap_q[15:12]);
            4'd12:   line1_s = bcd_char(snap_q[11:8]);
            4'd13:   line1_s = CH_COLON;
            4'd14:   line1_s = bcd_char(snap_q[7:4]);
            4'd15:   line1_s = bcd_char(snap_q[3:0]);
            default: line1_s = CH_SPACE;
        endcase
    end

    // Byte/oper for the current frame position, plus end-of-frame conditions.
    always_comb begin
        byte_d = 8'h00;
        oper_d = OPER_DATA;
        case (frame_q)
            FR_INIT: begin
                byte_d = init_byte(idx_q[1:0]);
                oper_d = OPER_INSTR;
            end
            FR_REFRESH: begin
                if (idx_q == 5'd0) begin
                    byte_d = L1_ADDR;
                    oper_d = OPER_INSTR;
                end else begin
                    byte_d = line1_s;
                end
            end
            FR_MESSAGE: begin
                if (idx_q == 5'd0) begin
                    byte_d = L2_ADDR;
                    oper_d = OPER_INSTR;
                end else begin
                    byte_d = rom_char_s;
                end
            end
            default: begin
                byte_d = 8'h00;
                oper_d = OPER_INSTR;
            end
        endcase
        last_s    = (frame_q == FR_INIT) ? (idx_q == INIT_LAST) : (idx_q == LINE_LAST);
        tmo_hit_s = (tmo_q == (TIMEOUT_CYC - 16'd1));
        abort_s   = tmo_hit_s && (((state_q == ST_WAIT_LOW) && lcd.lcd_rdy) ||
                                  ((state_q == ST_WAIT_HIGH) && !lcd.lcd_rdy));
        done_s    = (state_q == ST_WAIT_HIGH) && lcd.lcd_rdy && last_s;
    end

    // Frame arbitration, byte handshake FSM, pendings and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            frame_q        <= FR_INIT;
            idx_q          <= 5'd0;
            tmo_q          <= 16'd0;
            snap_q         <= 32'd0;
            msg_id_q       <= 2'd0;
            init_pend_q    <= 1'b1;
            refresh_pend_q <= 1'b0;
            msg_pend_q     <= 1'b0;
            msg_ack_q      <= 1'b0;
            err_q          <= 1'b0;
            enb_q          <= 1'b0;
            data_q         <= 8'h00;
            oper_q         <= OPER_INSTR;
        end else begin
            msg_ack_q <= 1'b0;
            enb_q     <= 1'b0;
            if (msg_req_i && !msg_pend_q) begin
                msg_pend_q <= 1'b1;
                msg_id_q   <= msg_id_i;
            end
            case (state_q)
                ST_IDLE: begin
                    idx_q <= 5'd0;
                    if (init_pend_q) begin
                        frame_q     <= FR_INIT;
                        init_pend_q <= 1'b0;
                        state_q     <= ST_ISSUE;
                    end else if (msg_pend_q) begin
                        frame_q <= FR_MESSAGE;
                        state_q <= ST_ISSUE;
                    end else if (refresh_pend_q) begin
                        frame_q        <= FR_REFRESH;
                        snap_q         <= count_time_i;
                        refresh_pend_q <= 1'b0;
                        state_q        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (lcd.lcd_rdy) begin
                        enb_q   <= 1'b1;
                        data_q  <= byte_d;
                        oper_q  <= oper_d;
                        tmo_q   <= 16'd0;
                        state_q <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (!lcd.lcd_rdy) begin
                        state_q <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (lcd.lcd_rdy) begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Completion and abort override the handshake step above.
            if (abort_s || done_s) begin
                state_q <= ST_IDLE;
                if (frame_q == FR_MESSAGE) begin
                    msg_ack_q  <= 1'b1;
                    msg_pend_q <= 1'b0;
                end
            end
            if (abort_s) begin
                err_q <= 1'b1;
            end
            // A tick landing in the refresh start cycle is kept rather than lost.
            if (refresh_tick_i) begin
                refresh_pend_q <= 1'b1;
            end
        end
    end

    assign lcd.lcd_data = data_q;
    assign lcd.lcd_oper = oper_q;
    assign lcd.lcd_enb  = enb_q;
    assign msg_ack_o    = msg_ack_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != ST_IDLE) || init_pend_q || msg_pend_q || refresh_pend_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Randomized bench for lcd_frame_scheduler with a behavioural LCD driver and frame model.
module tb_lcd_frame_scheduler;
    localparam logic [15:0] TMO = 16'd400;
    localparam time         PER = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] count_time;
    logic        tick, msg_req, msg_ack, busy, err;
    logic [1:0]  msg_id;
    logic        stuck;

    int total = 0;
    int bad   = 0;

    logic [9:0] cap[$];
    logic [9:0] exp_q[$];
    int         ack_pos[$];
    string      msgs[4];
    int         drv_cnt;
    logic       drv_act;
    time        rise_t;

    always #(PER / 2) clk = ~clk;

    lcd_frame_scheduler_if bus ();

    lcd_frame_scheduler #(
        .TIMEOUT_CYC (TMO),
        .L1_ADDR     (8'h80),
        .L2_ADDR     (8'hC0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .count_time_i   (count_time),
        .refresh_tick_i (tick),
        .msg_req_i      (msg_req),
        .msg_id_i       (msg_id),
        .msg_ack_o      (msg_ack),
        .lcd            (bus),
        .busy_o         (busy),
        .err_o          (err)
    );

    // Driver model: after an ENB, RDY drops 2 cycles later and rises 5 cycles after that.
    initial begin
        bus.lcd_rdy = 1'b1;
        drv_act = 1'b0;
        drv_cnt = 0;
        rise_t = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                drv_act = 1'b0;
                drv_cnt = 0;
                bus.lcd_rdy = 1'b1;
            end else if (drv_act) begin
                drv_cnt++;
                if (drv_cnt == 2) begin
                    bus.lcd_rdy = 1'b0;
                end else if (drv_cnt == 7) begin
                    bus.lcd_rdy = 1'b1;
                    rise_t = $time;
                    drv_act = 1'b0;
                end
            end else if (bus.lcd_enb === 1'b1 && !stuck) begin
                drv_act = 1'b1;
                drv_cnt = 0;
            end
        end
    end

    // Monitor: record every strobed byte and where in the byte stream each ack falls.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.lcd_enb === 1'b1) cap.push_back({bus.lcd_oper, bus.lcd_data});
            if (!rst && msg_ack === 1'b1) ack_pos.push_back(cap.size());
        end
    end

    function automatic logic [7:0] to_char(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h66) ? 8'h3F : c;
    endfunction

    task automatic add_init();
        exp_q.push_back(10'h038);
        exp_q.push_back(10'h00C);
        exp_q.push_back(10'h006);
        exp_q.push_back(10'h001);
    endtask

    // Hex-printing BCD shows out-of-range digits as a..f, which become '?'.
    task automatic add_refresh(input logic [31:0] t);
        string s;
        s = $sformatf("A %02h:%02h  B %02h:%02h", t[31:24], t[23:16], t[15:8], t[7:0]);
        exp_q.push_back({2'b00, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({2'b01, to_char(s[i])});
    endtask

    task automatic add_msg(input logic [1:0] id);
        string s;
        s = msgs[id];
        exp_q.push_back({2'b00, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({2'b01, 8'(s[i])});
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_msg(input logic [1:0] id);
        msg_id = id;
        msg_req = 1'b1;
        @(negedge clk);
        msg_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic wait_bytes(input int cnt);
        int n = 0;
        while (cap.size() < cnt && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.lcd_enb, bus.lcd_data, bus.lcd_oper, busy, msg_ack, err} !== {1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: enb=%b data=%h oper=%b busy=%b ack=%b err=%b, expected 0 00 00 1 0 0",
                     bus.lcd_enb, bus.lcd_data, bus.lcd_oper, busy, msg_ack, err);
        end
        cap.delete();
        exp_q.delete();
        add_init();
        rst = 1'b0;
        wait_idle("init");
        total++;
        if ($time - rise_t !== PER) begin
            bad++;
            $display("FAIL init_busy_fall: busy fell %0t after last RDY rise, expected %0t", $time - rise_t, PER);
        end
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL init_len: got %0d strobes, expected %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL init_byte[%0d]: got %h, expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_refresh();
        logic [31:0] pats[8];
        pats[0] = 32'h0512_0930;
        pats[1] = 32'h0A00_0000;
        for (int k = 2; k < 8; k++) pats[k] = $urandom;
        for (int k = 0; k < 8; k++) begin
            cap.delete();
            exp_q.delete();
            add_refresh(pats[k]);
            count_time = pats[k];
            pulse_tick();
            wait_bytes(3);
            count_time = $urandom;
            wait_idle("refresh");
            total++;
            if (cap.size() != exp_q.size()) begin
                bad++;
                $display("FAIL refresh_len[%0d]: got %0d strobes, expected %0d", k, cap.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
                total++;
                if (cap[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL refresh_byte[%0d][%0d]: got %h, expected %h (time %h)", k, i, cap[i], exp_q[i], pats[k]);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [31:0] t;
        t = $urandom;
        cap.delete();
        exp_q.delete();
        ack_pos.delete();
        add_msg(2'd1);
        add_refresh(t);
        count_time = t;
        msg_id = 2'd1;
        msg_req = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        msg_req = 1'b0;
        tick = 1'b0;
        wait_idle("priority");
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL priority_len: got %0d strobes, expected %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL priority_byte[%0d]: got %h, expected %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (ack_pos.size() != 1 || ack_pos[0] != 17) begin
            bad++;
            $display("FAIL priority_ack: %0d acks, first after byte %0d, expected 1 ack after byte 17",
                     ack_pos.size(), (ack_pos.size() > 0) ? ack_pos[0] : -1);
        end
    endtask

    task automatic test_coalesce();
        logic [31:0] t1, t2;
        t1 = $urandom;
        t2 = $urandom;
        cap.delete();
        exp_q.delete();
        add_refresh(t1);
        add_refresh(t2);
        count_time = t1;
        pulse_tick();
        wait_bytes(2);
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        count_time = t2;
        wait_idle("coalesce");
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL coalesce_len: got %0d strobes, expected %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL coalesce_byte[%0d]: got %h, expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_msg_ignore();
        logic [1:0] b;
        for (int a = 0; a < 4; a++) begin
            b = 2'($urandom_range(0, 3));
            cap.delete();
            exp_q.delete();
            ack_pos.delete();
            add_msg(2'(a));
            pulse_msg(2'(a));
            wait_bytes(3);
            pulse_msg(b);
            wait_idle("msg_ignore");
            total++;
            if (ack_pos.size() != 1) begin
                bad++;
                $display("FAIL msg_ignore_acks[%0d]: got %0d acks, expected 1", a, ack_pos.size());
            end
            total++;
            if (cap.size() != exp_q.size()) begin
                bad++;
                $display("FAIL msg_ignore_len[%0d]: got %0d strobes, expected %0d", a, cap.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
                total++;
                if (cap[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL msg_byte[%0d][%0d]: got %h, expected %h", a, i, cap[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic [31:0] t;
        cap.delete();
        ack_pos.delete();
        stuck = 1'b1;
        count_time = $urandom;
        pulse_tick();
        wait_bytes(1);
        repeat (int'(TMO) - 10) @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: err=%b before timeout, expected 0", err);
        end
        while (err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ({err, busy} !== 2'b10 || cap.size() != 1 || cap[0] !== 10'h080) begin
            bad++;
            $display("FAIL timeout_abort: err=%b busy=%b strobes=%0d, expected err=1 busy=0 one 080 strobe",
                     err, busy, cap.size());
        end
        pulse_msg(2'($urandom_range(0, 3)));
        wait_idle("timeout_msg");
        total++;
        if (ack_pos.size() != 1) begin
            bad++;
            $display("FAIL timeout_msg_ack: got %0d acks, expected 1", ack_pos.size());
        end
        stuck = 1'b0;
        t = $urandom;
        cap.delete();
        exp_q.delete();
        add_refresh(t);
        count_time = t;
        pulse_tick();
        wait_idle("after_timeout");
        total++;
        if (cap.size() != exp_q.size() || err !== 1'b1) begin
            bad++;
            $display("FAIL after_timeout: strobes=%0d err=%b, expected %0d strobes err=1", cap.size(), err, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL after_timeout_byte[%0d]: got %h, expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        count_time = $urandom;
        cap.delete();
        pulse_tick();
        wait_bytes(5);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.lcd_enb, bus.lcd_data, busy, err} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_vals: enb=%b data=%h busy=%b err=%b, expected 0 00 1 0",
                     bus.lcd_enb, bus.lcd_data, busy, err);
        end
        @(negedge clk);
        cap.delete();
        exp_q.delete();
        add_init();
        rst = 1'b0;
        wait_idle("reset_mid");
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL reset_mid_len: got %0d strobes, expected %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_mid_byte[%0d]: got %h, expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        msgs[0] = "SET TIME        ";
        msgs[1] = "A WINS ON TIME  ";
        msgs[2] = "B WINS ON TIME  ";
        msgs[3] = "PAUSED          ";
        rst = 1'b1;
        tick = 1'b0;
        msg_req = 1'b0;
        msg_id = 2'd0;
        count_time = 32'd0;
        stuck = 1'b0;
        @(negedge clk);
        test_reset();
        test_refresh();
        test_priority();
        test_coalesce();
        test_msg_ignore();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
